// File: rtl/pwm_capture_pkg.sv
// Shared register map, bit positions and capture-state encoding for the
// APB PWM period/high-time capture block.
package pwm_capture_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_PERIOD = 2'd2;
  localparam logic [1:0] OFF_HIGH   = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IE_NEW = 1;
  localparam int unsigned CTRL_IE_OVR = 2;
  localparam int unsigned CTRL_IE_TO  = 3;

  localparam int unsigned ST_NEW   = 0;
  localparam int unsigned ST_OVR   = 1;
  localparam int unsigned ST_TO    = 2;
  localparam int unsigned ST_LEVEL = 3;
  localparam int unsigned ST_ARMED = 4;

  typedef enum logic {
    CAP_IDLE  = 1'b0,
    CAP_ARMED = 1'b1
  } cap_state_e;

endpackage

// File: rtl/pwm_capture_apb_edge_sync.sv
// Multi-stage synchronizer for the asynchronous PWM input followed by a
// one-flop edge detector producing single-cycle rise/fall pulses.
module pwm_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0] r_sync;
  logic         r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[N-2:0], i_async};
      r_prev <= r_sync[N-1];
    end
  end

  assign o_level = r_sync[N-1];
  assign o_rise  = r_sync[N-1] & ~r_prev;
  assign o_fall  = ~r_sync[N-1] & r_prev;

endmodule

// File: rtl/pwm_capture_apb.sv
// APB3 completer measuring PWM period and high time in PCLK cycles, with
// W1C status, read-coherent HIGH shadow, timeout detection and a level IRQ.
module pwm_capture_apb
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        FABINT,
  input  logic        PWM_IN
);

  localparam logic [CNT_W-1:0] TO_SAT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);

  logic             w_level, w_rise, w_fall;
  logic             w_acc, w_err, w_wr, w_rd, w_en, w_armed;
  logic [1:0]       w_off;
  logic             w_unused;

  cap_state_e       r_state;
  logic [3:0]       r_ctrl;
  logic             r_new, r_ovr, r_to;
  logic             r_fabint;
  logic [CNT_W-1:0] r_period_cnt, r_high_cnt, r_high_hold;
  logic [CNT_W-1:0] r_period, r_high_raw, r_high_shadow;

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk   (PCLK),
    .i_rst_n (PRESETN),
    .i_async (PWM_IN),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_acc    = PSEL & PENABLE;
  assign w_err    = w_acc & (PADDR[31:4] != '0);
  assign w_wr     = w_acc & PWRITE & ~w_err;
  assign w_rd     = w_acc & ~PWRITE & ~w_err;
  assign w_off    = PADDR[3:2];
  assign w_en     = r_ctrl[CTRL_EN];
  assign w_armed  = (r_state == CAP_ARMED);
  assign w_unused = ^{PWDATA[31:4], PADDR[1:0]};

  assign PREADY  = 1'b1;
  assign PSLVERR = w_err;
  assign FABINT  = r_fabint;

  always_comb begin
    PRDATA = '0;
    if (w_rd) begin
      case (w_off)
        OFF_CTRL:   PRDATA = {28'd0, r_ctrl};
        OFF_STATUS: PRDATA = {27'd0, w_armed, w_level, r_to, r_ovr, r_new};
        OFF_PERIOD: PRDATA = 32'(r_period);
        default:    PRDATA = 32'(r_high_shadow);
      endcase
    end
  end

  // Shadow load uses the pre-edge HIGH_RAW so a coincident sample stays paired.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_ctrl        <= '0;
      r_high_shadow <= '0;
    end else begin
      if (w_wr && w_off == OFF_CTRL) r_ctrl <= PWDATA[3:0];
      if (w_rd && w_off == OFF_PERIOD) r_high_shadow <= r_high_raw;
    end
  end

  // Status W1C is applied first so hardware sets later in the block win.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state      <= CAP_IDLE;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_high_hold  <= '0;
      r_period     <= '0;
      r_high_raw   <= '0;
      r_new        <= 1'b0;
      r_ovr        <= 1'b0;
      r_to         <= 1'b0;
      r_fabint     <= 1'b0;
    end else begin
      r_fabint <= |({r_to, r_ovr, r_new} & r_ctrl[CTRL_IE_TO:CTRL_IE_NEW]);

      if (w_wr && w_off == OFF_STATUS) begin
        if (PWDATA[ST_NEW]) r_new <= 1'b0;
        if (PWDATA[ST_OVR]) r_ovr <= 1'b0;
        if (PWDATA[ST_TO])  r_to  <= 1'b0;
      end

      if (!w_en) begin
        r_state      <= CAP_IDLE;
        r_period_cnt <= '0;
        r_high_cnt   <= '0;
      end else begin
        if (w_rise)                       r_period_cnt <= '0;
        else if (r_period_cnt != TO_SAT)  r_period_cnt <= r_period_cnt + 1'b1;

        if (w_rise)                               r_high_cnt <= CNT_W'(1);
        else if (w_level && r_high_cnt != '1)     r_high_cnt <= r_high_cnt + 1'b1;

        if (w_fall) r_high_hold <= r_high_cnt;

        case (r_state)
          CAP_IDLE: begin
            if (w_rise) r_state <= CAP_ARMED;
          end
          CAP_ARMED: begin
            if (w_rise) begin
              r_period   <= r_period_cnt + 1'b1;
              r_high_raw <= r_high_hold;
              if (r_new) r_ovr <= 1'b1;
              r_new      <= 1'b1;
            end else if (r_period_cnt == TO_M1) begin
              r_state    <= CAP_IDLE;
              r_to       <= 1'b1;
              r_period   <= '0;
              r_high_raw <= w_level ? '1 : '0;
            end
          end
          default: r_state <= CAP_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture_apb.sv
// Directed bench for pwm_capture_apb: timestamp-based reference model checked
// every cycle, plus hand-computed register expectations.
module tb_pwm_capture_apb;

  localparam int unsigned TB_TIMEOUT = 500;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, FABINT;
  logic        PWM_IN = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic gen_on = 1'b0, force_on = 1'b0, force_val = 1'b0;
  int   gen_period = 100, gen_high = 30, phase = 0;

  always #5 PCLK = ~PCLK;

  pwm_capture_apb #(
    .CNT_W       (32),
    .TIMEOUT     (TB_TIMEOUT),
    .SYNC_STAGES (2)
  ) dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .FABINT  (FABINT),
    .PWM_IN  (PWM_IN)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // PWM source: free-running generator or a level forced by the sequence.
  always @(posedge PCLK) begin
    #2;
    if (force_on) PWM_IN = force_val;
    else if (gen_on) begin
      PWM_IN = (phase < gen_high);
      phase = (phase + 1 == gen_period) ? 0 : phase + 1;
    end else begin
      PWM_IN = 1'b0;
      phase = 0;
    end
  end

  // Reference model: edges become timestamps, period/high are timestamp differences.
  logic [3:0]  m_ctrl = '0;
  logic        m_new = 0, m_ovr = 0, m_to = 0, m_armed = 0, m_fab = 0;
  logic [31:0] m_period = '0, m_high_raw = '0, m_shadow = '0, m_hold = '0;
  int          n = 0, t_rise = 0, t_hrise = 0;
  logic        h0 = 0, h1 = 0, h2 = 0;
  logic        lv, rs, fl, acc, bad, wr, rd, nw, ov, tt;
  logic [2:0]  clr;

  always @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      m_ctrl = '0; m_new = 0; m_ovr = 0; m_to = 0; m_armed = 0; m_fab = 0;
      m_period = '0; m_high_raw = '0; m_shadow = '0; m_hold = '0;
      n = 0; t_rise = 0; t_hrise = 0; h0 = 0; h1 = 0; h2 = 0;
    end else begin
      n = n + 1;
      lv = h1;
      rs = h1 && !h2;
      fl = !h1 && h2;
      acc = PSEL && PENABLE;
      bad = acc && (PADDR[31:4] != 28'd0);
      wr = acc && PWRITE && !bad;
      rd = acc && !PWRITE && !bad;
      m_fab = |({m_to, m_ovr, m_new} & m_ctrl[3:1]);
      if (rd && PADDR[3:2] == 2'd2) m_shadow = m_high_raw;
      clr = (wr && PADDR[3:2] == 2'd1) ? PWDATA[2:0] : 3'b000;
      nw = m_new && !clr[0];
      ov = m_ovr && !clr[1];
      tt = m_to && !clr[2];
      if (m_ctrl[0]) begin
        if (fl) m_hold = 32'(n - t_hrise);
        if (rs) t_hrise = n;
        if (rs && !m_armed) begin
          m_armed = 1; t_rise = n;
        end else if (rs) begin
          m_period = 32'(n - t_rise);
          m_high_raw = m_hold;
          if (m_new) ov = 1;
          nw = 1;
          t_rise = n;
        end else if (m_armed && (n - t_rise) == int'(TB_TIMEOUT)) begin
          m_armed = 0; tt = 1; m_period = '0;
          m_high_raw = lv ? 32'hFFFF_FFFF : 32'h0;
        end
      end else begin
        m_armed = 0;
      end
      m_new = nw; m_ovr = ov; m_to = tt;
      if (wr && PADDR[3:2] == 2'd0) m_ctrl = PWDATA[3:0];
      h2 = h1; h1 = h0; h0 = PWM_IN;
    end
  end

  always @(negedge PCLK) begin
    logic [31:0] exp_rd;
    exp_rd = '0;
    if (PSEL && PENABLE && !PWRITE && PADDR[31:4] == 28'd0) begin
      case (PADDR[3:2])
        2'd0: exp_rd = {28'd0, m_ctrl};
        2'd1: exp_rd = {27'd0, m_armed, h1, m_to, m_ovr, m_new};
        2'd2: exp_rd = m_period;
        default: exp_rd = m_shadow;
      endcase
    end
    check("model FABINT", {31'd0, FABINT}, {31'd0, m_fab});
    check("model PSLVERR", {31'd0, PSLVERR}, {31'd0, PSEL && PENABLE && (PADDR[31:4] != 28'd0)});
    check("model PREADY", {31'd0, PREADY}, 32'd1);
    check("model PRDATA", PRDATA, exp_rd);
  end

  task automatic cyc();
    @(posedge PCLK); #1;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    cyc(); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
    cyc(); PENABLE = 1;
    cyc(); PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] mask,
                        input logic [31:0] exp, input logic exp_err);
    logic [31:0] d;
    logic        e;
    cyc(); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    cyc(); PENABLE = 1;
    @(negedge PCLK); d = PRDATA; e = PSLVERR;
    cyc(); PSEL = 0; PENABLE = 0;
    check(nm, d & mask, exp);
    check({nm, " err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  initial begin
    // Reset state
    repeat (3) cyc();
    check("reset FABINT", {31'd0, FABINT}, 32'd0);
    check("reset PRDATA", PRDATA, 32'd0);
    check("reset PSLVERR", {31'd0, PSLVERR}, 32'd0);
    PRESETN = 1;
    rd_chk("rst CTRL", 32'h0, '1, 32'h0, 0);
    rd_chk("rst STATUS", 32'h4, '1, 32'h0, 0);
    rd_chk("rst PERIOD", 32'h8, '1, 32'h0, 0);
    rd_chk("rst HIGH", 32'hC, '1, 32'h0, 0);
    check("PREADY", {31'd0, PREADY}, 32'd1);

    // Period 100 / high 30 with IE_NEW
    apb_write(32'h0, 32'h3);
    cyc(); gen_on = 1;
    repeat (150) cyc();
    rd_chk("PERIOD 100", 32'h8, '1, 32'd100, 0);
    rd_chk("HIGH 30", 32'hC, '1, 32'd30, 0);
    rd_chk("STATUS new+armed", 32'h4, '1, 32'h11, 0);
    apb_write(32'h4, 32'h1);
    @(negedge PCLK); check("FABINT at clear", {31'd0, FABINT}, 32'd1);
    @(negedge PCLK); check("FABINT after clear", {31'd0, FABINT}, 32'd0);

    // Two samples without clearing NEW -> overrun
    repeat (180) cyc();
    rd_chk("PERIOD latest", 32'h8, '1, 32'd100, 0);
    rd_chk("STATUS ovr", 32'h4, '1, 32'h13, 0);

    // Forced edges: W1C of OVR coincident with a sample, then coincident PERIOD read
    force_val = 0; force_on = 1;
    repeat (20) cyc();
    force_val = 1;
    apb_write(32'h4, 32'h2);
    rd_chk("STATUS ovr kept", 32'h4, '1, 32'h1B, 0);
    repeat (4) cyc(); force_val = 0;
    repeat (30) cyc(); force_val = 1;
    repeat (15) cyc(); force_val = 0;
    repeat (45) cyc(); force_val = 1;
    rd_chk("PERIOD old on edge", 32'h8, '1, 32'd40, 0);
    rd_chk("HIGH old on edge", 32'hC, '1, 32'd10, 0);
    rd_chk("PERIOD 60", 32'h8, '1, 32'd60, 0);
    rd_chk("HIGH 15", 32'hC, '1, 32'd15, 0);

    // Input stuck high -> timeout
    apb_write(32'h0, 32'h9);
    repeat (520) cyc();
    rd_chk("STATUS timeout", 32'h4, '1, 32'h0F, 0);
    rd_chk("PERIOD timeout", 32'h8, '1, 32'h0, 0);
    rd_chk("HIGH timeout", 32'hC, '1, 32'hFFFF_FFFF, 0);
    check("FABINT timeout", {31'd0, FABINT}, 32'd1);

    // Unmapped offsets
    rd_chk("read 0x10", 32'h10, '1, 32'h0, 1);
    apb_write(32'h10, 32'h0);
    apb_write(32'h14, 32'h7);
    rd_chk("CTRL intact", 32'h0, '1, 32'h9, 0);
    rd_chk("STATUS intact", 32'h4, '1, 32'h0F, 0);

    // Reset mid-measurement
    force_on = 0; gen_on = 0;
    cyc(); gen_on = 1;
    repeat (150) cyc();
    check("FABINT pre-reset", {31'd0, FABINT}, 32'd1);
    PRESETN = 0;
    #1;
    check("async rst FABINT", {31'd0, FABINT}, 32'd0);
    check("async rst PRDATA", PRDATA, 32'd0);
    repeat (3) cyc();
    PRESETN = 1;
    apb_write(32'h0, 32'h3);
    repeat (60) cyc();
    rd_chk("STATUS armed only", 32'h4, 32'h17, 32'h10, 0);
    rd_chk("PERIOD after rst", 32'h8, '1, 32'h0, 0);
    repeat (100) cyc();
    rd_chk("STATUS post-rst sample", 32'h4, 32'h17, 32'h11, 0);
    rd_chk("PERIOD post-rst", 32'h8, '1, 32'd100, 0);

    repeat (5) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
